// File: rtl/btn_debounce_pkg.sv
// Shared types and default sizing for the pushbutton debouncer.
package btn_debounce_pkg;

  // Default debounce window: 1 ms at a 50 MHz user clock.
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  // Default counter width; 2**16 covers any legal DEBOUNCE_CYCLES.
  localparam int CNT_W_DEF           = 16;

  // Debounce FSM: two stable levels, each with a waiting state in front of it.
  typedef enum logic [1:0] {
    IDLE_LOW    = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the raw pushbutton into the clock domain.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops; the first may go metastable.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their inputs from before the edge and form a true shift chain.
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Pushbutton debouncer: synchronizes the raw button, requires a stable run
// of DEBOUNCE_CYCLES before changing level, and emits one-cycle press and
// release pulses plus a running press count.
module btn_debounce_pulse
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       btn_i,
  input  logic       enable_i,
  output logic       btn_level_o,
  output logic       press_pulse_o,
  output logic       release_pulse_o,
  output logic [7:0] press_cnt_o,
  output logic       busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync;
  state_e           state_q,       state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic             press_q,       press_d;
  logic             release_q,     release_d;
  logic [7:0]       press_cnt_q,   press_cnt_d;

  sync_2ff u_sync (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .d_i    (btn_i),
    .q_o    (sync)
  );

  // Next-state logic: count consecutive cycles that disagree with the
  // current debounced level; any agreeing cycle aborts the wait.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    press_cnt_d = press_cnt_q;

    case (state_q)
      IDLE_LOW: begin
        if (sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          press_d = enable_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sync) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE_LOW;
          cnt_d     = '0;
          release_d = enable_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase

    // Press counter advances exactly when a press pulse is issued; wraps at 255.
    if (press_d) begin
      press_cnt_d = press_cnt_q + 8'd1;
    end
  end

  // State, counter and registered pulse outputs with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE_LOW;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign btn_level_o     = (state_q == STABLE_HIGH) || (state_q == WAIT_LOW);
  assign busy_o          = (state_q == WAIT_HIGH)   || (state_q == WAIT_LOW);
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign press_cnt_o     = press_cnt_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4.
module tb_btn_debounce_pulse;

  localparam int N  = 4;
  localparam int CW = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic       en    = 1'b1;
  logic       level;
  logic       press;
  logic       release_p;
  logic       busy;
  logic [7:0] pcnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (CW)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_ni       (rst_n),
    .btn_i           (btn),
    .enable_i        (en),
    .btn_level_o     (level),
    .press_pulse_o   (press),
    .release_pulse_o (release_p),
    .press_cnt_o     (pcnt),
    .busy_o          (busy)
  );

  // Reference model: the FSM sees the button two edges late; the debounced
  // level flips once the delayed input has disagreed with it on N+1
  // consecutive edges, and any agreeing edge restarts the run.
  int m_seen[$] = '{0, 0};
  bit m_level   = 1'b0;
  int m_run     = 0;
  bit m_press   = 1'b0;
  bit m_release = 1'b0;
  int m_cnt     = 0;

  logic [11:0] obs;
  assign obs = {level, busy, press, release_p, pcnt};

  function automatic logic [11:0] exp_vec();
    logic [7:0] c;
    c = m_cnt[7:0];
    return {m_level, (m_run > 0), m_press, m_release, c};
  endfunction

  task automatic model_edge();
    int s;
    if (!rst_n) begin
      m_seen    = '{0, 0};
      m_level   = 1'b0;
      m_run     = 0;
      m_press   = 1'b0;
      m_release = 1'b0;
      m_cnt     = 0;
    end else begin
      s = m_seen.pop_front();
      m_seen.push_back(int'(btn));
      m_press   = 1'b0;
      m_release = 1'b0;
      if (s != int'(m_level)) begin
        m_run++;
        if (m_run == N + 1) begin
          m_level = (s != 0);
          m_run   = 0;
          if (en) begin
            if (m_level) begin
              m_press = 1'b1;
              m_cnt   = (m_cnt + 1) % 256;
            end else begin
              m_release = 1'b1;
            end
          end
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge,
  // then sample DUT outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      btn = 1'($urandom_range(0, 1));
      step();
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("FAIL reset_outputs step %0d: got %h want %h", i, obs, 12'h000);
      end
    end
    rst_n = 1'b1;
    btn   = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("FAIL idle_after_reset step %0d: got %h want %h", i, obs, 12'h000);
      end
    end
  endtask

  task automatic test_clean_press();
    btn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      total++;
      if (press !== (i == 7)) begin
        bad++;
        $display("FAIL clean_press_pulse step %0d: got %b want %b", i, press, (i == 7));
      end
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL clean_press_model step %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    total++;
    if (level !== 1'b1) begin
      bad++;
      $display("FAIL clean_press_level: got %b want 1", level);
    end
    total++;
    if (pcnt !== 8'd1) begin
      bad++;
      $display("FAIL clean_press_count: got %0d want 1", pcnt);
    end
  endtask

  task automatic test_release_bounce();
    int releases = 0;
    btn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      releases += int'(release_p);
    end
    btn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      releases += int'(release_p);
      total++;
      if (level !== 1'b1) begin
        bad++;
        $display("FAIL bounce_level step %0d: got %b want 1", i, level);
      end
    end
    btn = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      releases += int'(release_p);
      total++;
      if (release_p !== (i == 7)) begin
        bad++;
        $display("FAIL release_pulse step %0d: got %b want %b", i, release_p, (i == 7));
      end
    end
    total++;
    if (releases != 1) begin
      bad++;
      $display("FAIL release_count: got %0d want 1", releases);
    end
  endtask

  task automatic test_glitch();
    int busy_cycles = 0;
    int pulses      = 0;
    for (int i = 0; i < 10; i++) begin
      btn = (i < 3);
      step();
      busy_cycles += int'(busy);
      pulses      += int'(press) + int'(release_p);
      total++;
      if (level !== 1'b0) begin
        bad++;
        $display("FAIL glitch_level step %0d: got %b want 0", i, level);
      end
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL glitch_model step %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    total++;
    if (busy_cycles != 3) begin
      bad++;
      $display("FAIL glitch_busy_cycles: got %0d want 3", busy_cycles);
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL glitch_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_disabled();
    int pulses = 0;
    en  = 1'b0;
    btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      pulses += int'(press) + int'(release_p);
    end
    total++;
    if (level !== 1'b1) begin
      bad++;
      $display("FAIL disabled_level_high: got %b want 1", level);
    end
    total++;
    if (pcnt !== 8'd1) begin
      bad++;
      $display("FAIL disabled_count: got %0d want 1", pcnt);
    end
    btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      pulses += int'(press) + int'(release_p);
    end
    total++;
    if (level !== 1'b0) begin
      bad++;
      $display("FAIL disabled_level_low: got %b want 0", level);
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL disabled_pulses: got %0d want 0", pulses);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    btn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (obs !== 12'h000) begin
        bad++;
        $display("FAIL reset_mid_outputs step %0d: got %h want %h", i, obs, 12'h000);
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      total++;
      if (press !== (i == 7)) begin
        bad++;
        $display("FAIL reset_mid_pulse step %0d: got %b want %b", i, press, (i == 7));
      end
    end
    total++;
    if (pcnt !== 8'd1) begin
      bad++;
      $display("FAIL reset_mid_count: got %0d want 1", pcnt);
    end
    btn = 1'b0;
    for (int i = 0; i < 9; i++) step();
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    btn   = 1'b0;
    step();
    rst_n = 1'b1;
    for (int p = 1; p <= 256; p++) begin
      for (int i = 0; i < 16; i++) begin
        btn = (i < 8);
        step();
        total++;
        if (obs !== exp_vec()) begin
          bad++;
          $display("FAIL wrap_model press %0d step %0d: got %h want %h", p, i, obs, exp_vec());
        end
      end
      if (p == 255) begin
        total++;
        if (pcnt !== 8'd255) begin
          bad++;
          $display("FAIL wrap_count_255: got %0d want 255", pcnt);
        end
      end
    end
    total++;
    if (pcnt !== 8'd0) begin
      bad++;
      $display("FAIL wrap_count_0: got %0d want 0", pcnt);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        btn  = ~btn;
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 49) == 0) en = ~en;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL random_model cycle %0d: got %h want %h", i, obs, exp_vec());
      end
    end
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release_bounce();
    test_glitch();
    test_disabled();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
